drive_mode_arbiter: RTL
=======================

// Module: drive_mode_arbiter
// PURPOSE
//  Owns the drive datapath and shares it between the manual, semi-auto and auto controllers.
//  Debounces the mode switch and grants exactly one enable at a time.
//  Between grants, forces a stop (handoff) window so no controller drives during a switch.
//  Masks conflicting commands and drives the single registered motion command toward the car.
// PARAMETERS
//  STABLE_TIME   10  cycles mode_sel must hold unchanged before it is accepted (0.02 s @500Hz)
//  HANDOFF_TIME  50  cycles of forced stop between two grants (0.1 s @500Hz)
//  CNT_W         16  width of both internal counters; must hold max(STABLE_TIME,HANDOFF_TIME)
// PORTS
//  clk          in   1  500 Hz control clock
//  rst_n        in   1  asynchronous active-low reset
//  power_on     in   1  car powered; low forces OFF
//  mode_sel     in   2  requested mode: 00 none, 01 manual, 10 semi-auto, 11 auto
//  man_cmd      in   4  manual command {fwd,left,right,back}
//  semi_cmd     in   4  semi-auto command {fwd,left,right,back}
//  auto_cmd     in   4  auto command {fwd,left,right,back}
//  man_en       out  1  grant to manual controller
//  semi_en      out  1  grant to semi-auto controller
//  auto_en      out  1  grant to auto controller
//  drive_cmd    out  4  masked command to chassis {fwd,left,right,back}
//  active_mode  out  2  code of the granted mode; 00 in OFF and HANDOFF
//  switching    out  1  high while in HANDOFF
// BEHAVIOUR
//  - All flops update on the falling edge of clk.
//  - Reset (async, rst_n=0): state=OFF, sel_q=00, stable_cnt=0, hcnt=0, target=00, drive_cmd=0.
//    All outputs are 0 immediately, including during any mode or HANDOFF.
//  - Debounce
//    - sel_q<=mode_sel every edge.
//    - stable_cnt<=0 if mode_sel!=sel_q; otherwise it increments, saturating at STABLE_TIME-1.
//    - req_ok=(stable_cnt==STABLE_TIME-1); accepted request req=sel_q.
//  - States: OFF, MANUAL, SEMI, AUTO, HANDOFF.
//    - man_en/semi_en/auto_en/switching/active_mode decode the state register only (Moore, no glitches).
//  - Transitions (priority order)
//    1. !power_on: any state -> OFF; hcnt=0.
//    2. OFF, req_ok, req!=00: -> HANDOFF, target=req, hcnt=0.
//    3. MANUAL/SEMI/AUTO, req_ok, req!=own code: -> HANDOFF, target=req (00 means target OFF), hcnt=0.
//    4. HANDOFF, req_ok, req!=target: stay; target=req, hcnt restarts at 0.
//    5. HANDOFF, hcnt==HANDOFF_TIME-1: -> state(target), i.e. 00->OFF, 01->MANUAL, 10->SEMI, 11->AUTO.
//    6. Otherwise hold. In HANDOFF, hcnt increments each edge.
//  - No-change cases
//    - req equal to the current mode, or to target while in HANDOFF, is no action and does not restart hcnt.
//    - OFF with req=00 holds.
//  - drive_cmd (registered, 1-cycle latency after the state register)
//    - !power_on, OFF or HANDOFF: drive_cmd<=0.
//    - MANUAL/SEMI/AUTO: drive_cmd<=the selected source's cmd after masking.
//    - Mask: fwd&back both set -> both cleared; left&right both set -> both cleared.
//  - Timing from a mode_sel change at edge 0, held steady:
//    - switching rises after edge STABLE_TIME+1.
//    - The new grant rises after edge STABLE_TIME+1+HANDOFF_TIME.
//  - Power restore: re-entry from OFF goes through HANDOFF on the next edge once req_ok holds with req!=00.
//  - rst_n deasserted mid-handoff: restarts from OFF; the full debounce and handoff apply again.
// TESTING
//  1. Bring-up: rst_n 0->1, power_on=1, mode_sel 00->01 at edge 0 (STABLE=10, HANDOFF=50).
//     -> switching=1 after edge 11; man_en=1, switching=0, active_mode=01 after edge 61.
//  2. Glitch filter: in MANUAL, mode_sel=10 for 5 cycles then back to 01.
//     -> switching never rises; man_en stays 1.
//  3. Retarget: in MANUAL select 10; after 20 HANDOFF cycles change to 11.
//     -> hcnt restarts once 11 is debounced; semi_en never rises; auto_en rises 50 edges after the retarget.
//  4. Conflict mask: in MANUAL, man_cmd=1001 -> drive_cmd=0000; 1100 -> 1100; 0110 -> 0000; 1110 -> 1000.
//  5. Power drop: in SEMI with semi_cmd=1000, power_on->0.
//     -> after the next edge semi_en=0, drive_cmd=0000, state OFF.
//  6. Async reset: in AUTO, assert rst_n=0 mid-cycle.
//     -> all outputs 0 before the next edge; after release, full debounce+handoff before any grant.

Source files
------------

// File: rtl/drive_mode_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : drive_mode_arbiter
// Purpose  : Shares the drive datapath between the manual, semi-auto and auto
//            controllers. Debounces the mode switch, grants exactly one
//            controller at a time, inserts a forced-stop handoff window
//            between grants, and registers the masked motion command.
// Ports    : clk          500 Hz control clock (flops update on falling edge)
//            rst_n        asynchronous active-low reset
//            power_on     car powered; low forces OFF
//            mode_sel     requested mode: 00 none, 01 man, 10 semi, 11 auto
//            man_cmd      manual command    {fwd,left,right,back}
//            semi_cmd     semi-auto command {fwd,left,right,back}
//            auto_cmd     auto command      {fwd,left,right,back}
//            man_en       grant to manual controller
//            semi_en      grant to semi-auto controller
//            auto_en      grant to auto controller
//            drive_cmd    masked command to chassis {fwd,left,right,back}
//            active_mode  code of the granted mode; 00 in OFF and HANDOFF
//            switching    high while in HANDOFF
// Revision : 1.0  initial release
// ============================================================================
module drive_mode_arbiter #(
  parameter int STABLE_TIME  = 10,
  parameter int HANDOFF_TIME = 50,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_on,
  input  logic [1:0] mode_sel,
  input  logic [3:0] man_cmd,
  input  logic [3:0] semi_cmd,
  input  logic [3:0] auto_cmd,
  output logic       man_en,
  output logic       semi_en,
  output logic       auto_en,
  output logic [3:0] drive_cmd,
  output logic [1:0] active_mode,
  output logic       switching
);

  localparam logic [CNT_W-1:0] STABLE_MAX  = CNT_W'(STABLE_TIME - 1);
  localparam logic [CNT_W-1:0] HANDOFF_MAX = CNT_W'(HANDOFF_TIME - 1);

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_MAN  = 2'b01;
  localparam logic [1:0] MODE_SEMI = 2'b10;
  localparam logic [1:0] MODE_AUTO = 2'b11;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_MANUAL  = 3'd1,
    ST_SEMI    = 3'd2,
    ST_AUTO    = 3'd3,
    ST_HANDOFF = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       target_q, target_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [3:0]       drive_cmd_q, drive_cmd_d;
  logic             req_ok;
  logic [1:0]       req;

  function automatic state_t code_to_state(input logic [1:0] code);
    case (code)
      MODE_MAN:  return ST_MANUAL;
      MODE_SEMI: return ST_SEMI;
      MODE_AUTO: return ST_AUTO;
      default:   return ST_OFF;
    endcase
  endfunction

  // Opposing directions cancel each other rather than letting one win.
  function automatic logic [3:0] mask_cmd(input logic [3:0] cmd);
    logic [3:0] m;
    m = cmd;
    if (cmd[3] && cmd[0]) begin
      m[3] = 1'b0;
      m[0] = 1'b0;
    end
    if (cmd[2] && cmd[1]) begin
      m[2] = 1'b0;
      m[1] = 1'b0;
    end
    return m;
  endfunction

  // Moore decode of the state register only.
  assign man_en    = (state_q == ST_MANUAL);
  assign semi_en   = (state_q == ST_SEMI);
  assign auto_en   = (state_q == ST_AUTO);
  assign switching = (state_q == ST_HANDOFF);
  assign drive_cmd = drive_cmd_q;

  always_comb begin
    active_mode = MODE_NONE;
    case (state_q)
      ST_MANUAL: active_mode = MODE_MAN;
      ST_SEMI:   active_mode = MODE_SEMI;
      ST_AUTO:   active_mode = MODE_AUTO;
      default:   active_mode = MODE_NONE;
    endcase
  end

  // Debounce: a request is accepted only once mode_sel has matched its
  // registered copy for STABLE_TIME consecutive edges.
  always_comb begin
    sel_d = mode_sel;
    if (mode_sel != sel_q) begin
      stable_cnt_d = '0;
    end else if (stable_cnt_q == STABLE_MAX) begin
      stable_cnt_d = stable_cnt_q;
    end else begin
      stable_cnt_d = stable_cnt_q + CNT_W'(1);
    end
    req_ok = (stable_cnt_q == STABLE_MAX);
    req    = sel_q;
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    hcnt_d   = '0;
    if (!power_on) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (req_ok && (req != MODE_NONE)) begin
            state_d  = ST_HANDOFF;
            target_d = req;
          end
        end
        ST_MANUAL, ST_SEMI, ST_AUTO: begin
          // active_mode carries the own code of the granted state here.
          if (req_ok && (req != active_mode)) begin
            state_d  = ST_HANDOFF;
            target_d = req;
          end
        end
        ST_HANDOFF: begin
          // A retarget wins over completion and restarts the stop window.
          if (req_ok && (req != target_q)) begin
            target_d = req;
          end else if (hcnt_q == HANDOFF_MAX) begin
            state_d = code_to_state(target_q);
          end else begin
            hcnt_d = hcnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Command register follows the current state register, one edge behind.
  always_comb begin
    drive_cmd_d = 4'b0000;
    if (power_on) begin
      case (state_q)
        ST_MANUAL: drive_cmd_d = mask_cmd(man_cmd);
        ST_SEMI:   drive_cmd_d = mask_cmd(semi_cmd);
        ST_AUTO:   drive_cmd_d = mask_cmd(auto_cmd);
        default:   drive_cmd_d = 4'b0000;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      sel_q        <= MODE_NONE;
      target_q     <= MODE_NONE;
      stable_cnt_q <= '0;
      hcnt_q       <= '0;
      drive_cmd_q  <= 4'b0000;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      target_q     <= target_d;
      stable_cnt_q <= stable_cnt_d;
      hcnt_q       <= hcnt_d;
      drive_cmd_q  <= drive_cmd_d;
    end
  end

endmodule
`default_nettype wire
